stream_test_driver: RTL

Parametrised, synthesisable successor to the single-stream integration driver. It fires exactly one control token into the DUT's `inCtrl` port with a proper valid/ready handshake. It then drains `NUM_STREAMS` result streams of `{data, eos}` elements under a configurable back-pressure pattern, keeping per-channel element counts and checksums. Completion and timeout are reported as status outputs, so benches and on-FPGA harnesses can both use it.

---
 rtl/stream_test_driver_pkg.sv | 19 +
 rtl/stream_test_driver_if.sv | 37 +++
 rtl/stream_test_driver_chan.sv | 58 +++++
 rtl/stream_test_driver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/stream_test_driver_pkg.sv
// Shared types and helpers for the stream test driver: FSM state encoding,
// phase pointer width and the per-channel bus slice offset.
package stream_test_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } drv_state_e;

  localparam int PHASE_W = 3;

  function automatic int chan_offset(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/stream_test_driver_if.sv
// Handshake bundle between the test driver (master) and the design under
// test (slave): one control token each way plus NUM_STREAMS result streams.
interface stream_test_driver_if #(
  parameter int NUM_STREAMS = 2,
  parameter int DATA_WIDTH  = 64
);
  logic                              inCtrl_valid;
  logic                              inCtrl_ready;
  logic                              outCtrl_valid;
  logic                              outCtrl_ready;
  logic [NUM_STREAMS-1:0]            out_valid;
  logic [NUM_STREAMS-1:0]            out_ready;
  logic [NUM_STREAMS*DATA_WIDTH-1:0] out_data;
  logic [NUM_STREAMS-1:0]            out_eos;

  modport master (
    output inCtrl_valid,
    input  inCtrl_ready,
    input  outCtrl_valid,
    output outCtrl_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_eos
  );

  modport slave (
    input  inCtrl_valid,
    output inCtrl_ready,
    output outCtrl_valid,
    input  outCtrl_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_eos
  );
endinterface

// File: rtl/stream_test_driver_chan.sv
// One result-stream consumer: counts non-EOS elements, accumulates a wrapping
// checksum and latches EOS, after which the channel ignores further traffic.
module stream_test_driver_chan #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic                   ready_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   eos_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic [DATA_WIDTH-1:0]  sum_o,
  output logic                   eos_seen_o
);
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic                   eos_q, eos_d;
  logic                   hs;

  assign hs = valid_i && ready_i && !eos_q;

  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    eos_d   = eos_q;
    if (clear_i) begin
      count_d = '0;
      sum_d   = '0;
      eos_d   = 1'b0;
    end else if (hs) begin
      if (eos_i) begin
        eos_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
        sum_d   = sum_q + data_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      sum_q   <= '0;
      eos_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      eos_q   <= eos_d;
    end
  end

  assign count_o    = count_q;
  assign sum_o      = sum_q;
  assign eos_seen_o = eos_q;
endmodule

// File: rtl/stream_test_driver.sv
// Fires one control token, drains NUM_STREAMS result streams under a rotating
// ready mask and reports done/timeout. STREAM_TEST_DRIVER_DISPLAY_EN adds sim prints.
module stream_test_driver
  import stream_test_driver_pkg::*;
#(
  parameter int         DATA_WIDTH     = 64,
  parameter int         NUM_STREAMS    = 2,
  parameter int         COUNT_WIDTH    = 32,
  parameter logic [7:0] READY_PATTERN  = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  stream_test_driver_if.master               bus,
  output logic [NUM_STREAMS*COUNT_WIDTH-1:0] elem_count,
  output logic [NUM_STREAMS*DATA_WIDTH-1:0]  checksum,
  output logic [NUM_STREAMS-1:0]             eos_seen,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout
);
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(TIMEOUT_CYCLES);

  drv_state_e             state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   ctrl_rx_q, ctrl_rx_d;
  logic                   active, clear, in_hs, out_hs, any_hs;
  logic [NUM_STREAMS-1:0] stream_hs, eos_next;

  assign active    = (state_q == ST_FIRE) || (state_q == ST_RUN);
  assign clear     = start && (state_q inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
  assign in_hs     = bus.inCtrl_valid && bus.inCtrl_ready;
  assign out_hs    = bus.outCtrl_valid && bus.outCtrl_ready;
  assign any_hs    = in_hs || out_hs || (|stream_hs);

  assign bus.inCtrl_valid  = (state_q == ST_FIRE);
  assign bus.outCtrl_ready = active;
  // Ready depends only on registered state so the DUT sees no combinational loop.
  assign bus.out_ready     = (active && READY_PATTERN[phase_q]) ? ~eos_seen : '0;

  assign busy    = active;
  assign done    = (state_q == ST_DONE);
  assign timeout = (state_q == ST_TIMEOUT);

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_chan
    localparam int DOFF = chan_offset(gi, DATA_WIDTH);
    localparam int COFF = chan_offset(gi, COUNT_WIDTH);

    assign stream_hs[gi] = bus.out_valid[gi] && bus.out_ready[gi];
    assign eos_next[gi]  = eos_seen[gi] || (stream_hs[gi] && bus.out_eos[gi]);

    stream_test_driver_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (clear),
      .valid_i   (bus.out_valid[gi]),
      .ready_i   (bus.out_ready[gi]),
      .data_i    (bus.out_data[DOFF +: DATA_WIDTH]),
      .eos_i     (bus.out_eos[gi]),
      .count_o   (elem_count[COFF +: COUNT_WIDTH]),
      .sum_o     (checksum[DOFF +: DATA_WIDTH]),
      .eos_seen_o(eos_seen[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idle_d    = idle_q;
    ctrl_rx_d = ctrl_rx_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d   = ST_FIRE;
          phase_d   = '0;
          idle_d    = '0;
          ctrl_rx_d = 1'b0;
        end
      end
      ST_FIRE, ST_RUN: begin
        phase_d = phase_q + 1'b1;
        idle_d  = any_hs ? '0 : idle_q + 1'b1;
        if (out_hs) ctrl_rx_d = 1'b1;
        // Completion looks at this cycle's handshakes so done trails the last one by a cycle.
        if (state_q == ST_FIRE && in_hs) begin
          state_d = ST_RUN;
        end else if (state_q == ST_RUN && (&eos_next) && ctrl_rx_d) begin
          state_d = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0 && !any_hs && idle_d == TIMEOUT_VAL) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      idle_q    <= '0;
      ctrl_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idle_q    <= idle_d;
      ctrl_rx_q <= ctrl_rx_d;
    end
  end

`ifdef STREAM_TEST_DRIVER_DISPLAY_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NUM_STREAMS; c++) begin
        if (stream_hs[c]) begin
          if (bus.out_eos[c]) $display("ch%0d EOS", c);
          else $display("ch%0d Element=%0d", c, bus.out_data[chan_offset(c, DATA_WIDTH) +: DATA_WIDTH]);
        end
      end
      if (state_d == ST_DONE && state_q != ST_DONE) begin
        $display("DONE");
        $finish;
      end
      if (state_d == ST_TIMEOUT && state_q != ST_TIMEOUT) begin
        $display("TIMEOUT");
        $fatal(1, "stream_test_driver timed out");
      end
    end
  end
`endif
endmodule
